compound_out_arbiter: RTL and testbench

COMPOUND_OUT_ARBITER -- requirements
Module: compound_out_arbiter

---
 rtl/compound_arb_types.sv | 26 ++
 rtl/rr_arbiter2.sv | 35 +++
 rtl/compound_out_arbiter.sv | 70 +++++++
 tb/tb_compound_out_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/compound_arb_types.sv
// Shared types for the compound output arbiter: payload struct, FSM states, requester count.
package compound_arb_types;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int COUNT_W = 8;

  typedef enum logic {
    MODE_READ  = 1'b0,
    MODE_WRITE = 1'b1
  } mode_e;

  typedef struct packed {
    mode_e mode;
    int    x;
    logic  y;
  } CompoundType;

  typedef enum logic {
    SECTION_IDLE = 1'b0,
    SECTION_HOLD = 1'b1
  } Sections;

  localparam CompoundType COMPOUND_RESET = '{mode: MODE_READ, x: 0, y: 1'b0};

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way winner selection: sole valid wins, otherwise the side not granted last.
// With COMPOUND_ARB_WRITE_PRIO_EN defined, a write request beats a read request.
module rr_arbiter2
  import compound_arb_types::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic [NUM_REQ-1:0] is_write,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  // NOTE: every output gets a default first so no path through always_comb leaves it unassigned (no latch).
  always_comb begin
    any    = |valid;
    winner = '0;
    if (valid == 2'b10) begin
      winner = 1'b1;
    end else if (valid == 2'b11) begin
`ifdef COMPOUND_ARB_WRITE_PRIO_EN
      if (is_write[0] != is_write[1]) winner = is_write[1];
      else                            winner = ~ptr;
`else
      winner = ~ptr;
`endif
    end
  end

`ifndef COMPOUND_ARB_WRITE_PRIO_EN
  // Modes only matter when write priority is built in.
  logic unused_is_write;
  assign unused_is_write = ^is_write;
`endif

endmodule

// File: rtl/compound_out_arbiter.sv
// Two requesters share one registered output with notify/sync handshake and a transfer counter.
// Optional write-over-read priority via COMPOUND_ARB_WRITE_PRIO_EN.
module compound_out_arbiter
  import compound_arb_types::*;
(
  input  logic               clk,
  input  logic               rst,
  input  CompoundType        req0_data,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  CompoundType        req1_data,
  input  logic               req1_valid,
  output logic               req1_ready,
  output CompoundType        b_out,
  output logic               b_out_notify,
  input  logic               b_out_sync,
  output logic [ID_W-1:0]    grant_id,
  output logic [COUNT_W-1:0] xfer_count
);

  Sections           state, state_next;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   winner;
  logic              any;
  logic              take;
  logic              accepting;
  logic              grant;

  rr_arbiter2 u_rr_arbiter2 (
    .valid    ({req1_valid, req0_valid}),
    .is_write ({req1_data.mode == MODE_WRITE, req0_data.mode == MODE_WRITE}),
    .ptr      (ptr),
    .winner   (winner),
    .any      (any)
  );

  // A held word can be replaced in the same cycle the consumer takes it.
  always_comb begin
    take       = (state == SECTION_HOLD) && b_out_sync;
    accepting  = (state == SECTION_IDLE) || b_out_sync;
    grant      = accepting && any;
    state_next = state;
    if (grant)     state_next = SECTION_HOLD;
    else if (take) state_next = SECTION_IDLE;
  end

  assign req0_ready   = grant && (winner == 1'b0);
  assign req1_ready   = grant && (winner == 1'b1);
  assign b_out_notify = (state == SECTION_HOLD);

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SECTION_IDLE;
      b_out      <= COMPOUND_RESET;
      grant_id   <= '0;
      xfer_count <= '0;
      ptr        <= 1'b1;
    end else begin
      state <= state_next;
      if (take) xfer_count <= xfer_count + 1'b1;
      if (grant) begin
        b_out    <= winner ? req1_data : req0_data;
        grant_id <= winner;
        ptr      <= winner;
      end
    end
  end

endmodule

// File: tb/tb_compound_out_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_compound_out_arbiter;
  import compound_arb_types::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  CompoundType req0_data, req1_data;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  CompoundType b_out;
  logic        b_out_notify;
  logic        b_out_sync = 1'b0;
  logic        grant_id;
  logic [7:0]  xfer_count;

  int errors = 0;
  int checks = 0;

  // Reference model state: what the consumer should currently see.
  bit          m_notify;
  CompoundType m_out;
  int          m_gid;
  int          m_count;
  int          m_last;

  always #5 clk = ~clk;

  compound_out_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req0_data    (req0_data),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req1_data    (req1_data),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .b_out        (b_out),
    .b_out_notify (b_out_notify),
    .b_out_sync   (b_out_sync),
    .grant_id     (grant_id),
    .xfer_count   (xfer_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic CompoundType mk(input bit wr, input int x, input bit y);
    CompoundType c;
    c.mode = wr ? MODE_WRITE : MODE_READ;
    c.x    = x;
    c.y    = y;
    return c;
  endfunction

  function automatic CompoundType rnd_payload();
    return mk(1'($urandom_range(0, 1)), int'($urandom), 1'($urandom_range(0, 1)));
  endfunction

  // Who should win given the offers; -1 when nobody offers.
  function automatic int model_pick(input bit v0, input bit v1, input CompoundType d0, input CompoundType d1);
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
    if (!v0 && !v1) return -1;
`ifdef COMPOUND_ARB_WRITE_PRIO_EN
    if (d0.mode == MODE_WRITE && d1.mode == MODE_READ) return 0;
    if (d1.mode == MODE_WRITE && d0.mode == MODE_READ) return 1;
`endif
    return 1 - m_last;
  endfunction

  task automatic model_reset();
    m_notify = 1'b0;
    m_out    = mk(1'b0, 0, 1'b0);
    m_gid    = 0;
    m_count  = 0;
    m_last   = 1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".notify"}, 64'(b_out_notify), 64'(m_notify));
    check({tag, ".b_out"},  64'(b_out),        64'(m_out));
    check({tag, ".gid"},    64'(grant_id),     64'(m_gid));
    check({tag, ".count"},  64'(xfer_count),   64'(m_count));
  endtask

  // One clock of traffic: drive, check readies, clock, advance model, check outputs.
  task automatic cycle(input string tag, input CompoundType d0, input bit v0,
                       input CompoundType d1, input bit v1, input bit s);
    int w;
    bit acc;
    req0_data = d0; req0_valid = v0;
    req1_data = d1; req1_valid = v1;
    b_out_sync = s;
    #1;
    acc = !m_notify || s;
    w   = acc ? model_pick(v0, v1, d0, d1) : -1;
    check({tag, ".rdy0"}, 64'(req0_ready), 64'(w == 0));
    check({tag, ".rdy1"}, 64'(req1_ready), 64'(w == 1));
    @(posedge clk);
    #1;
    if (m_notify && s) m_count = (m_count + 1) % 256;
    if (w >= 0) begin
      m_out    = (w == 0) ? d0 : d1;
      m_gid    = w;
      m_last   = w;
      m_notify = 1'b1;
    end else if (m_notify && s) begin
      m_notify = 1'b0;
    end
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  CompoundType idle_d;

  initial begin
    idle_d = mk(1'b0, 0, 1'b0);
    req0_data = idle_d;
    req1_data = idle_d;
    do_reset();

    // Single write request with the consumer stalled; result must stay put.
    cycle("single", mk(1'b1, 5, 1'b1), 1'b1, idle_d, 1'b0, 1'b0);
    check("single.bx",   64'(b_out.x),    64'd5);
    check("single.mode", 64'(b_out.mode), 64'(MODE_WRITE));
    for (int i = 0; i < 10; i++)
      cycle("stable", idle_d, 1'b0, mk(1'b0, 9, 1'b0), (i % 2) == 1, 1'b0);

    // Continuous contention, consumer always ready: alternate grants, count +1 per cycle.
    for (int i = 0; i < 8; i++)
      cycle("alt", mk(1'b0, 100 + i, 1'b0), 1'b1, mk(1'b0, -200 - i, 1'b1), 1'b1, 1'b1);
    cycle("drain", idle_d, 1'b0, idle_d, 1'b0, 1'b1);

    // Mode priority with the pointer favouring requester 0.
    do_reset();
    cycle("prio", mk(1'b0, 1, 1'b0), 1'b1, mk(1'b1, 2, 1'b1), 1'b1, 1'b0);
`ifdef COMPOUND_ARB_WRITE_PRIO_EN
    check("prio.winner", 64'(grant_id), 64'd1);
`else
    check("prio.winner", 64'(grant_id), 64'd0);
`endif
    cycle("prio2", idle_d, 1'b0, idle_d, 1'b0, 1'b1);

    // 256 separate transfers wrap the counter; idle syncs must not count.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      cycle("wrap_ld", mk(1'b0, i, 1'b0), 1'b1, idle_d, 1'b0, 1'b0);
      cycle("wrap_tk", idle_d, 1'b0, idle_d, 1'b0, 1'b1);
    end
    check("wrap.count", 64'(xfer_count), 64'd0);
    for (int i = 0; i < 4; i++)
      cycle("idle_sync", idle_d, 1'b0, idle_d, 1'b0, 1'b1);

    // Asynchronous reset while holding data.
    cycle("hold", mk(1'b1, 77, 1'b1), 1'b1, idle_d, 1'b0, 1'b0);
    cycle("hold2", idle_d, 1'b0, mk(1'b1, 78, 1'b0), 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle("post_rst", mk(1'b0, 3, 1'b0), 1'b1, mk(1'b0, 4, 1'b1), 1'b1, 1'b0);
    check("post_rst.gid", 64'(grant_id), 64'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle("rand", rnd_payload(), 1'($urandom_range(0, 1)), rnd_payload(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
